// File: rtl/cancel_cache_arbiter.sv
// Arbitrates exchange write requests and CPU read requests onto a single cache port, one transaction at a time.
// Optional abort timer on a stalled cache is enabled by defining CACHE_ARB_TIMEOUT_EN.
//
//   state  | meaning
//   IDLE   | ready to grant; exch_done pulse shows here after a write
//   BUSY   | cache request outstanding, fields held stable
//   RESP   | one-cycle CPU read response
module cancel_cache_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT_CYC  = 255
) (
    input  logic        clk,
    input  logic        HRESETn,
    input  logic        exch_valid,
    output logic        exch_ready,
    input  logic [4:0]  exch_client_id,
    input  logic [15:0] exch_amount,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic [9:0]  cpu_client_id,
    output logic        cpu_rsp_valid,
    output logic [31:0] cpu_rsp_data,
    output logic        exch_done,
    output logic        cache_req_valid,
    output logic        cache_req_rw,
    output logic [31:0] cache_req_index,
    output logic [31:0] cache_req_data,
    input  logic        cache_res_ready,
    input  logic [31:0] cache_res_data,
    output logic        timeout_err
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          rw_q, rw_d;
    logic [31:0]   index_q, index_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          exch_done_q, exch_done_d;
    logic          grant_cpu, grant_exch;

`ifdef CACHE_ARB_TIMEOUT_EN
    logic [7:0]    tmo_cnt_q, tmo_cnt_d;
    logic [7:0]    tmo_next;
    logic          timeout_err_q, timeout_err_d;
`endif

    // CPU only overtakes a pending exchange once it has been starved STARVE_LIMIT times.
    always_comb begin
        grant_cpu  = cpu_valid && (!exch_valid || (starve_cnt_q == LIM));
        grant_exch = exch_valid && !grant_cpu;
    end

    always_comb begin
        exch_ready      = HRESETn && (state_q == S_IDLE) && grant_exch;
        cpu_ready       = HRESETn && (state_q == S_IDLE) && grant_cpu;
        cache_req_valid = (state_q == S_BUSY);
        cache_req_rw    = (state_q == S_BUSY) && rw_q;
        cache_req_index = (state_q == S_BUSY) ? index_q : 32'd0;
        cache_req_data  = (state_q == S_BUSY) ? wdata_q : 32'd0;
        cpu_rsp_valid   = (state_q == S_RESP);
        cpu_rsp_data    = (state_q == S_RESP) ? rsp_data_q : 32'd0;
        exch_done       = exch_done_q;
`ifdef CACHE_ARB_TIMEOUT_EN
        timeout_err     = timeout_err_q;
`else
        timeout_err     = 1'b0;
`endif
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        rw_d         = rw_q;
        index_d      = index_q;
        wdata_d      = wdata_q;
        rsp_data_d   = rsp_data_q;
        exch_done_d  = 1'b0;
`ifdef CACHE_ARB_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        tmo_next      = tmo_cnt_q + 8'd1;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_exch) begin
                    state_d = S_BUSY;
                    rw_d    = 1'b1;
                    index_d = {18'b0, 5'b0, exch_client_id, 4'b0};
                    wdata_d = {16'b0, exch_amount};
                    if (!cpu_valid) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != LIM) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else if (grant_cpu) begin
                    state_d      = S_BUSY;
                    rw_d         = 1'b0;
                    index_d      = {18'b0, cpu_client_id, 4'b0};
                    wdata_d      = 32'd0;
                    starve_cnt_d = '0;
                end else if (!cpu_valid) begin
                    starve_cnt_d = '0;
                end
`ifdef CACHE_ARB_TIMEOUT_EN
                tmo_cnt_d = 8'd0;
`endif
            end
            S_BUSY: begin
                if (cache_res_ready) begin
                    if (rw_q) begin
                        exch_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        rsp_data_d = cache_res_data;
                        state_d    = S_RESP;
                    end
                end
`ifdef CACHE_ARB_TIMEOUT_EN
                else if (tmo_next == 8'(TIMEOUT_CYC)) begin
                    // Abort still completes the requester's handshake so neither side hangs.
                    timeout_err_d = 1'b1;
                    tmo_cnt_d     = 8'd0;
                    if (rw_q) begin
                        exch_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        rsp_data_d = 32'hFFFF_FFFF;
                        state_d    = S_RESP;
                    end
                end else begin
                    tmo_cnt_d = tmo_next;
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= S_IDLE;
            starve_cnt_q <= '0;
            rw_q         <= 1'b0;
            index_q      <= 32'd0;
            wdata_q      <= 32'd0;
            rsp_data_q   <= 32'd0;
            exch_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            rw_q         <= rw_d;
            index_q      <= index_d;
            wdata_q      <= wdata_d;
            rsp_data_q   <= rsp_data_d;
            exch_done_q  <= exch_done_d;
        end
    end

`ifdef CACHE_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            tmo_cnt_q     <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_cancel_cache_arbiter.sv
// Directed bench for cancel_cache_arbiter: write, read, fairness, reset abandon, optional timeout abort.
module tb_cancel_cache_arbiter;

    logic        clk = 1'b0;
    logic        HRESETn = 1'b0;
    logic        exch_valid = 1'b0;
    logic        exch_ready;
    logic [4:0]  exch_client_id = '0;
    logic [15:0] exch_amount = '0;
    logic        cpu_valid = 1'b0;
    logic        cpu_ready;
    logic [9:0]  cpu_client_id = '0;
    logic        cpu_rsp_valid;
    logic [31:0] cpu_rsp_data;
    logic        exch_done;
    logic        cache_req_valid;
    logic        cache_req_rw;
    logic [31:0] cache_req_index;
    logic [31:0] cache_req_data;
    logic        cache_res_ready = 1'b0;
    logic [31:0] cache_res_data = '0;
    logic        timeout_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    cancel_cache_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .HRESETn(HRESETn),
        .exch_valid(exch_valid), .exch_ready(exch_ready),
        .exch_client_id(exch_client_id), .exch_amount(exch_amount),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_client_id(cpu_client_id),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data),
        .exch_done(exch_done),
        .cache_req_valid(cache_req_valid), .cache_req_rw(cache_req_rw),
        .cache_req_index(cache_req_index), .cache_req_data(cache_req_data),
        .cache_res_ready(cache_res_ready), .cache_res_data(cache_res_data),
        .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic edge_then_drive();
        @(posedge clk);
        #1;
    endtask

    initial begin
        automatic byte grants[$];
        automatic byte exp_order[6] = '{"E", "E", "E", "E", "C", "E"};
        automatic int  multi_ready = 0;
        automatic int  rsp_seen = 0;
        automatic int  busy_cycles = 0;

        // reset state
        #12;
        chk("rst_exch_ready", {31'b0, exch_ready}, 0);
        chk("rst_cpu_ready", {31'b0, cpu_ready}, 0);
        chk("rst_cache_req_valid", {31'b0, cache_req_valid}, 0);
        chk("rst_exch_done", {31'b0, exch_done}, 0);
        chk("rst_cpu_rsp_valid", {31'b0, cpu_rsp_valid}, 0);
        chk("rst_timeout_err", {31'b0, timeout_err}, 0);

        // write: client 3, amount 100, cache ready after 2 cycles
        @(negedge clk);
        HRESETn = 1'b1;
        exch_valid = 1'b1; exch_client_id = 5'd3; exch_amount = 16'd100;
        #1;
        chk("wr_exch_ready", {31'b0, exch_ready}, 1);
        chk("wr_cpu_ready", {31'b0, cpu_ready}, 0);
        edge_then_drive();
        exch_valid = 1'b0;
        @(negedge clk);
        chk("wr_req_valid", {31'b0, cache_req_valid}, 1);
        chk("wr_req_rw", {31'b0, cache_req_rw}, 1);
        chk("wr_req_index", cache_req_index, 32'h30);
        chk("wr_req_data", cache_req_data, 32'd100);
        chk("wr_exch_ready_busy", {31'b0, exch_ready}, 0);
        edge_then_drive();
        @(negedge clk);
        chk("wr_req_stable", cache_req_index, 32'h30);
        chk("wr_done_early", {31'b0, exch_done}, 0);
        cache_res_ready = 1'b1;
        edge_then_drive();
        cache_res_ready = 1'b0;
        @(negedge clk);
        chk("wr_exch_done", {31'b0, exch_done}, 1);
        chk("wr_req_valid_after", {31'b0, cache_req_valid}, 0);
        edge_then_drive();
        @(negedge clk);
        chk("wr_exch_done_pulse", {31'b0, exch_done}, 0);

        // stray cache_res_ready in IDLE is ignored
        cache_res_ready = 1'b1;
        edge_then_drive();
        cache_res_ready = 1'b0;
        @(negedge clk);
        chk("idle_ignore_done", {31'b0, exch_done}, 0);
        chk("idle_ignore_rsp", {31'b0, cpu_rsp_valid}, 0);

        // read: client 17, cache returns 250
        cpu_valid = 1'b1; cpu_client_id = 10'd17;
        #1;
        chk("rd_cpu_ready", {31'b0, cpu_ready}, 1);
        edge_then_drive();
        cpu_valid = 1'b0;
        @(negedge clk);
        chk("rd_req_valid", {31'b0, cache_req_valid}, 1);
        chk("rd_req_rw", {31'b0, cache_req_rw}, 0);
        chk("rd_req_index", cache_req_index, 32'h110);
        cache_res_ready = 1'b1; cache_res_data = 32'd250;
        edge_then_drive();
        cache_res_ready = 1'b0; cache_res_data = 32'd0;
        @(negedge clk);
        chk("rd_rsp_valid", {31'b0, cpu_rsp_valid}, 1);
        chk("rd_rsp_data", cpu_rsp_data, 32'd250);
        chk("rd_req_valid_resp", {31'b0, cache_req_valid}, 0);
        edge_then_drive();
        @(negedge clk);
        chk("rd_rsp_pulse", {31'b0, cpu_rsp_valid}, 0);

        // fairness: both requesters held high, 1-cycle cache
        exch_valid = 1'b1; exch_client_id = 5'd1;
        cpu_valid = 1'b1; cpu_client_id = 10'd2;
        cache_res_ready = 1'b1;
        for (int c = 0; c < 60 && grants.size() < 6; c++) begin
            #1;
            if (exch_ready && cpu_ready) multi_ready++;
            if (exch_ready) grants.push_back("E");
            else if (cpu_ready) grants.push_back("C");
            @(negedge clk);
        end
        exch_valid = 1'b0; cpu_valid = 1'b0;
        chk("fair_grant_count", grants.size(), 6);
        chk("fair_one_ready", multi_ready, 0);
        for (int i = 0; i < 6 && i < grants.size(); i++)
            chk($sformatf("fair_grant%0d", i), {24'b0, grants[i]}, {24'b0, exp_order[i]});
        repeat (4) @(negedge clk);
        cache_res_ready = 1'b0;
        @(negedge clk);

        // reset during a BUSY read abandons it
        cpu_valid = 1'b1; cpu_client_id = 10'd5;
        edge_then_drive();
        cpu_valid = 1'b0;
        @(negedge clk);
        chk("rstb_busy", {31'b0, cache_req_valid}, 1);
        #2;
        HRESETn = 1'b0;
        cache_res_ready = 1'b1; cache_res_data = 32'h1234;
        #1;
        chk("rstb_req_valid", {31'b0, cache_req_valid}, 0);
        chk("rstb_req_index", cache_req_index, 32'd0);
        chk("rstb_rsp_valid", {31'b0, cpu_rsp_valid}, 0);
        @(negedge clk);
        cache_res_ready = 1'b0;
        HRESETn = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (cpu_rsp_valid) rsp_seen++;
        end
        chk("rstb_no_rsp", rsp_seen, 0);

        // first grant right after reset release
        HRESETn = 1'b0;
        #2;
        @(negedge clk);
        HRESETn = 1'b1;
        exch_valid = 1'b1; exch_client_id = 5'd31; exch_amount = 16'hFFFF;
        #1;
        chk("rel_exch_ready", {31'b0, exch_ready}, 1);
        edge_then_drive();
        exch_valid = 1'b0;
        @(negedge clk);
        chk("rel_req_index", cache_req_index, 32'h1F0);
        chk("rel_req_data", cache_req_data, 32'h0000_FFFF);
        cache_res_ready = 1'b1;
        edge_then_drive();
        cache_res_ready = 1'b0;
        @(negedge clk);
        chk("rel_exch_done", {31'b0, exch_done}, 1);

`ifdef CACHE_ARB_TIMEOUT_EN
        // read with a cache that never answers aborts after 8 BUSY cycles
        cpu_valid = 1'b1; cpu_client_id = 10'd9;
        edge_then_drive();
        cpu_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!cache_req_valid) break;
            busy_cycles++;
        end
        chk("tmo_busy_cycles", busy_cycles, 8);
        chk("tmo_err", {31'b0, timeout_err}, 1);
        chk("tmo_rsp_valid", {31'b0, cpu_rsp_valid}, 1);
        chk("tmo_rsp_data", cpu_rsp_data, 32'hFFFF_FFFF);
        @(negedge clk);
        exch_valid = 1'b1; exch_client_id = 5'd2; exch_amount = 16'd7;
        #1;
        chk("tmo_next_ready", {31'b0, exch_ready}, 1);
        edge_then_drive();
        exch_valid = 1'b0;
        @(negedge clk);
        chk("tmo_next_index", cache_req_index, 32'h20);
        chk("tmo_err_sticky", {31'b0, timeout_err}, 1);
        cache_res_ready = 1'b1;
        edge_then_drive();
        cache_res_ready = 1'b0;
`else
        // without the timer a stalled cache keeps the request up indefinitely
        cpu_valid = 1'b1; cpu_client_id = 10'd9;
        edge_then_drive();
        cpu_valid = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (cache_req_valid) busy_cycles++;
        end
        chk("notmo_busy_cycles", busy_cycles, 300);
        chk("notmo_err", {31'b0, timeout_err}, 0);
        cache_res_ready = 1'b1; cache_res_data = 32'hABCD;
        edge_then_drive();
        cache_res_ready = 1'b0;
        @(negedge clk);
        chk("notmo_rsp_data", cpu_rsp_data, 32'hABCD);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cancel_cache_arbiter.md
CANCEL_CACHE_ARBITER -- requirements
Module: cancel_cache_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive exchange grants while a CPU request waits.
REQ-002 Parameter TIMEOUT_CYC, default 255: cache-wait cycles before abort (only with CACHE_ARB_TIMEOUT_EN).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 HRESETn  in  1  asynchronous active-low reset.
REQ-005 exch_valid / exch_ready  in / out  1 / 1  exchange write-request handshake.
REQ-006 exch_client_id / exch_amount  in  5 / 16  client to update, cancelled amount.
REQ-007 cpu_valid / cpu_ready  in / out  1 / 1  CPU read-request handshake.
REQ-008 cpu_client_id  in  10  client whose cancelled total is read.
REQ-009 cpu_rsp_valid / cpu_rsp_data  out  1 / 32  read response pulse and data.
REQ-010 exch_done  out  1  one-cycle pulse on write completion.
REQ-011 cache_req_valid / cache_req_rw  out  1 / 1  cache request; rw=1 write, 0 read.
REQ-012 cache_req_index / cache_req_data  out  32 / 32  cache address, write data.
REQ-013 cache_res_ready / cache_res_data  in  1 / 32  cache completion, read data.
REQ-014 timeout_err  out  1  sticky abort flag.

Function
REQ-015 FSM states IDLE, BUSY, RESP; exactly one cache transaction outstanding.
REQ-016 Ready outputs are high only in IDLE, combinational from state and grant; at most one ready high per cycle.
REQ-017 IDLE grant: exchange wins if exch_valid, unless cpu_valid and starve_cnt==STARVE_LIMIT, then CPU wins.
REQ-018 starve_cnt increments on each exchange grant while cpu_valid high, clears on CPU grant or when cpu_valid low in IDLE; saturates at STARVE_LIMIT.
REQ-019 Accept (valid&ready) at cycle N latches rw, index, data; BUSY entered at N+1.
REQ-020 Index: write {18'b0, 5'b0, exch_client_id, 4'b0}; read {18'b0, cpu_client_id, 4'b0}; write data {16'b0, exch_amount}.
REQ-021 BUSY: cache_req_valid=1 and fields stable until cache_res_ready sampled high.
REQ-022 BUSY with cache_res_ready=1: write -> exch_done=1 next cycle, return IDLE; read -> capture cache_res_data, enter RESP.
REQ-023 RESP: cpu_rsp_valid=1 for exactly one cycle with captured data, then IDLE; no back-pressure.
REQ-024 cache_req_valid, cpu_rsp_valid, exch_done are 0 in every other state.
REQ-025 cache_res_ready high outside BUSY is ignored.
REQ-026 Simultaneous exch_valid and cpu_valid with starve_cnt<STARVE_LIMIT: exchange granted, CPU stays pending.
REQ-027 Requests dropped by a requester before acceptance are not remembered.

Reset
REQ-028 HRESETn low forces IDLE, starve_cnt=0, timeout counter=0, all outputs 0, latched fields 0, immediately and asynchronously.
REQ-029 Reset mid-BUSY abandons the transaction: no exch_done, no cpu_rsp_valid afterwards.
REQ-030 First grant possible in the first clk edge after HRESETn deasserts.

Configuration
REQ-031 Macro CACHE_ARB_TIMEOUT_EN defined: 8-bit counter runs in BUSY; reaching TIMEOUT_CYC without cache_res_ready sets timeout_err (sticky until reset), drops cache_req_valid, returns IDLE; aborted read gives cpu_rsp_valid pulse with data 32'hFFFF_FFFF, aborted write gives exch_done pulse.
REQ-032 Macro undefined: no counter, BUSY waits indefinitely, timeout_err tied 0.

Verification
REQ-033 Write: exch client 5'd3, amount 16'd100, cache ready after 2 cycles -> index 32'h30, data 32'd100, rw=1, exch_done one cycle after ready.
REQ-034 Read: cpu client 10'd17, cache returns 32'd250 -> index 32'h110, rw=0, cpu_rsp_valid one cycle with 32'd250.
REQ-035 Fairness: exch_valid and cpu_valid held high, 1-cycle cache -> grant order E,E,E,E,C,E,... (STARVE_LIMIT=4).
REQ-036 HRESETn low during BUSY read -> all outputs 0 same cycle, no cpu_rsp_valid after release.
REQ-037 With CACHE_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, cache never ready on read -> after 8 BUSY cycles timeout_err=1, cpu_rsp_data 32'hFFFF_FFFF, next request accepted.
